ring_decoder_monitor: RTL
=========================

# ring_decoder_monitor

Receive-side companion to the team's one-hot ring counter. Samples an external WIDTH-bit one-hot ring vector on a strobe, decodes it to a binary index, checks that it is exactly one-hot and advances one position per sample, and acquires/loses lock accordingly. It keeps a saturating error counter and a full-revolution counter for status readout. It sits between the ring counter output (or its board-level copy) and the status/LED logic of the FPGA top.

## Interface
- WIDTH, 8: ring vector width; must be a power of two, ≥ 2; IDX_W = log2(WIDTH)
- LOCK_CNT, 4: consecutive correct steps required to enter LOCKED; range 1..255
- ERR_W, 8: error counter width
- REV_W, 16: revolution counter width
- clk_i  input  1  clock; all logic on rising edge
- sys_rst_n  input  1  reset, asynchronous, active-low
- ring_i  input  WIDTH  ring vector under test (synchronous to clk_i)
- ring_vld_i  input  1  sample strobe; ring_i evaluated only when high
- clr_i  input  1  synchronous clear of state and counters
- index_o  output  IDX_W  decoded bit position of last valid one-hot sample
- index_vld_o  output  1  one-cycle pulse: index_o updated this cycle
- onehot_err_o  output  1  one-cycle pulse: sample had zero or ≥2 bits set
- seq_err_o  output  1  one-cycle pulse: sequence break while LOCKED
- locked_o  output  1  level: state is LOCKED
- err_cnt_o  output  ERR_W  saturating count of onehot_err and seq_err events
- rev_cnt_o  output  REV_W  wrapping count of full revolutions while LOCKED

## Operation
- States: ACQUIRE, LOCKED. Internal: prev_idx (IDX_W), prev_vld, run (8 bit).
- Sample = rising edge with ring_vld_i=1 and clr_i=0.
- Invalid sample (popcount ≠ 1, incl. all-zero): onehot_err_o=1; index_vld_o=0; index_o holds; err_cnt++ (either state); prev_vld←0; run←0; state←ACQUIRE.
- Valid sample, bit k set: index_o←k; index_vld_o=1; prev_idx←k; prev_vld←1. Then:
  - prev_vld=0: run←0, state unchanged (ACQUIRE).
  - k == (prev_idx+1) mod WIDTH (correct step): run←run+1 (saturating at 255). In ACQUIRE, if run+1 ≥ LOCK_CNT → LOCKED. In LOCKED, if prev_idx=WIDTH-1 and k=0 → rev_cnt++.
  - otherwise (incl. repeated index, backward step, skip): in LOCKED: seq_err_o=1, err_cnt++, state←ACQUIRE; in either state run←0 (this sample becomes new reference).
- Transition into LOCKED does not itself count a revolution; the wrap step that causes lock (prev=WIDTH-1, k=0, in ACQUIRE) does not increment rev_cnt.
- err_cnt saturates at 2^ERR_W−1; rev_cnt wraps modulo 2^REV_W.
- ring_vld_i=0: no state change; all pulse outputs 0; index_o, counters, locked_o hold.
- clr_i=1: state←ACQUIRE, prev_vld←0, run←0, err_cnt←0, rev_cnt←0, pulses 0, index_o←0; overrides a simultaneous sample (sample discarded).
- onehot_err_o and seq_err_o never both high in one cycle.

## Timing
- Reset (async assert, sync-to-clock release expected upstream): index_o=0, index_vld_o=0, onehot_err_o=0, seq_err_o=0, locked_o=0, err_cnt_o=0, rev_cnt_o=0, state ACQUIRE, prev_vld=0, run=0.
- Latency: all outputs registered; responses to a sample visible after the same edge that takes the sample (1 cycle from ring_vld_i/ring_i setup to output).
- Pulses last exactly one cycle; back-to-back samples give back-to-back pulses.
- locked_o rises on the edge of the sample completing LOCK_CNT correct steps; falls on the edge of the offending sample (or clr_i/reset).
- Reset asserted mid-operation: all outputs go to reset values immediately, no clock needed.

## Test plan
- Reset: hold sys_rst_n low with ring_i=8'h01, ring_vld_i=1 → all outputs 0, locked_o=0; release → first sample gives index_o=0, index_vld_o=1, locked_o=0.
- Lock: samples 01,02,04,08,10 (LOCK_CNT=4) → index_o 0..4, locked_o=1 after the 5th sample edge, err_cnt_o=0.
- Revolution: continue locked through 20,40,80,01 → rev_cnt_o=1 after 01; 80 more full revolutions → rev_cnt_o=81; gaps in ring_vld_i change nothing.
- One-hot error: locked, sample 8'h03 then 8'h00 → onehot_err_o pulses twice, index_o unchanged, locked_o=0, err_cnt_o=2.
- Sequence error: locked at index 2, sample 8'h10 → seq_err_o=1, index_o=4, err_cnt_o+1, locked_o=0; then 20,40,80,01 → relock on the 4th.
- Clear/saturation: 300 invalid samples → err_cnt_o=255; clr_i=1 with ring_vld_i=1 same cycle → counters 0, index_vld_o=0, locked_o=0.

Source files
------------

// File: rtl/ring_decoder_monitor_if.sv
// Sample/status bundle between a ring source and ring_decoder_monitor.
// The master drives the ring sample side; the slave is the monitor.
interface ring_decoder_monitor_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8,
    parameter int REV_W = 16
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_i;
    logic             ring_vld_i;
    logic             clr_i;
    logic [IDX_W-1:0] index_o;
    logic             index_vld_o;
    logic             onehot_err_o;
    logic             seq_err_o;
    logic             locked_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic [REV_W-1:0] rev_cnt_o;

    modport master (
        output ring_i, ring_vld_i, clr_i,
        input  index_o, index_vld_o, onehot_err_o, seq_err_o, locked_o, err_cnt_o, rev_cnt_o
    );

    modport slave (
        input  ring_i, ring_vld_i, clr_i,
        output index_o, index_vld_o, onehot_err_o, seq_err_o, locked_o, err_cnt_o, rev_cnt_o
    );
endinterface

// File: rtl/ring_decoder_monitor.sv
// Decodes a sampled one-hot ring vector, tracks step-by-step advance and
// lock, and keeps saturating error / wrapping revolution counters.
module ring_decoder_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter int REV_W    = 16,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  sys_rst_n,
    ring_decoder_monitor_if.slave bus
);
    typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
    logic             prev_vld_q, prev_vld_d;
    logic [7:0]       run_q, run_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             idx_vld_q, idx_vld_d;
    logic             oh_err_q, oh_err_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [REV_W-1:0] rev_q, rev_d;

    logic             onehot;
    logic [IDX_W-1:0] k;
    logic             step_ok;
    logic [ERR_W-1:0] err_inc;
    logic [7:0]       run_inc;

    // x & (x-1) clears the lowest set bit, so zero result plus nonzero x means exactly one bit.
    always_comb begin
        onehot = (|bus.ring_i) && ~|(bus.ring_i & (bus.ring_i - WIDTH'(1)));
        k = '0;
        for (int i = 0; i < WIDTH; i++)
            if (bus.ring_i[i]) k = IDX_W'(i);
        step_ok = prev_vld_q && (k == IDX_W'(prev_idx_q + 1'b1));
        err_inc = (err_q == '1) ? err_q : err_q + 1'b1;
        run_inc = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end

    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        prev_vld_d = prev_vld_q;
        run_d      = run_q;
        index_d    = index_q;
        idx_vld_d  = 1'b0;
        oh_err_d   = 1'b0;
        seq_err_d  = 1'b0;
        err_d      = err_q;
        rev_d      = rev_q;
        if (bus.clr_i) begin
            state_d    = ACQUIRE;
            prev_vld_d = 1'b0;
            run_d      = '0;
            index_d    = '0;
            err_d      = '0;
            rev_d      = '0;
        end else if (bus.ring_vld_i) begin
            if (!onehot) begin
                oh_err_d   = 1'b1;
                err_d      = err_inc;
                prev_vld_d = 1'b0;
                run_d      = '0;
                state_d    = ACQUIRE;
            end else begin
                index_d    = k;
                idx_vld_d  = 1'b1;
                prev_idx_d = k;
                prev_vld_d = 1'b1;
                if (!prev_vld_q) begin
                    run_d = '0;
                end else if (step_ok) begin
                    run_d = run_inc;
                    // The wrap that completes lock is taken in ACQUIRE and so is not a revolution.
                    if (state_q == ACQUIRE) begin
                        if ({1'b0, run_q} + 9'd1 >= 9'(LOCK_CNT)) state_d = LOCKED;
                    end else if (prev_idx_q == IDX_W'(WIDTH - 1) && k == '0) begin
                        rev_d = rev_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                    if (state_q == LOCKED) begin
                        seq_err_d = 1'b1;
                        err_d     = err_inc;
                        state_d   = ACQUIRE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ACQUIRE;
            prev_idx_q <= '0;
            prev_vld_q <= 1'b0;
            run_q      <= '0;
            index_q    <= '0;
            idx_vld_q  <= 1'b0;
            oh_err_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            err_q      <= '0;
            rev_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_idx_q <= prev_idx_d;
            prev_vld_q <= prev_vld_d;
            run_q      <= run_d;
            index_q    <= index_d;
            idx_vld_q  <= idx_vld_d;
            oh_err_q   <= oh_err_d;
            seq_err_q  <= seq_err_d;
            err_q      <= err_d;
            rev_q      <= rev_d;
        end
    end

    assign bus.index_o      = index_q;
    assign bus.index_vld_o  = idx_vld_q;
    assign bus.onehot_err_o = oh_err_q;
    assign bus.seq_err_o    = seq_err_q;
    assign bus.locked_o     = (state_q == LOCKED);
    assign bus.err_cnt_o    = err_q;
    assign bus.rev_cnt_o    = rev_q;
endmodule
